// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single-port memory between instruction fetch
// and load/store data. Data has priority; a read occupies the memory for two
// cycles (grant in IDLE, data returned in WAIT); stores complete in one cycle.
//
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   if_req/if_addr                 fetch request in
//   if_ready/if_rvalid/if_rdata    fetch accept / read data out
//   d_req/d_we/d_addr/d_wdata      data request in
//   d_ready/d_rvalid/d_rdata       data accept / load data out
//   mem_write_en/mem_addr/mem_write_data  to memory
//   mem_read_data                  from memory (one cycle after address)
//
// Optional feature: define MEM_ARB_STARVE_GUARD_EN to force a fetch grant
// after STARVE_MAX consecutive data grants made while fetch was waiting.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_write_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t state_q, state_d;
  logic   owner_q, owner_d;   // 0 = fetch, 1 = data
  logic   fetch_turn;         // fetch overrides data priority this cycle

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_q;

  // Counts data grants taken while fetch is waiting; never exceeds STARVE_MAX
  // because reaching it hands the next grant to fetch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else if (state_q == IDLE) begin
      if (!if_req || if_ready) begin
        starve_q <= '0;
      end else if (d_ready) begin
        starve_q <= starve_q + CNT_W'(1);
      end
    end
  end

  assign fetch_turn = if_req && (starve_q == CNT_W'(STARVE_MAX));
`else
  // STARVE_MAX only matters when the guard is built in.
  logic unused_starve_max;
  assign unused_starve_max = ^32'(STARVE_MAX);
  assign fetch_turn = 1'b0;
`endif

  // State and owner registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  // Grant selection, memory steering and read-data return. Everything is
  // qualified by rst_n so a reset asserted in WAIT suppresses the return.
  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    if_ready       = 1'b0;
    d_ready        = 1'b0;
    if_rvalid      = 1'b0;
    d_rvalid       = 1'b0;
    if_rdata       = '0;
    d_rdata        = '0;
    mem_write_en   = 1'b0;
    mem_addr       = '0;
    mem_write_data = '0;
    case (state_q)
      IDLE: begin
        if (rst_n) begin
          if (d_req && !fetch_turn) begin
            d_ready        = 1'b1;
            mem_addr       = d_addr;
            mem_write_data = d_wdata;
            mem_write_en   = d_we;
            if (!d_we) begin
              state_d = WAIT;
              owner_d = 1'b1;
            end
          end else if (if_req) begin
            if_ready = 1'b1;
            mem_addr = if_addr;
            state_d  = WAIT;
            owner_d  = 1'b0;
          end
        end
      end
      WAIT: begin
        state_d = IDLE;
        if (rst_n) begin
          if (owner_q) begin
            d_rvalid = 1'b1;
            d_rdata  = mem_read_data;
          end else begin
            if_rvalid = 1'b1;
            if_rdata  = mem_read_data;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
